lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side companion to the 32-bit Fibonacci LFSR pattern source.
//  Consumes the serial stream of new LSBs the generator shifts in each step.
//  Self-synchronises to that stream, then predicts every following bit.
//  Flags and counts mismatches. Used for link/BIST checks of the graphics
//  noise and pattern path.
// PARAMETERS
//  TAPS       32'h9010_2302  feedback mask (bits 31,28,20,13,9,8,1); fb = ^(sr & TAPS)
//  LOCK_CNT   64             consecutive correct predictions needed to declare lock
//  LOSS_THRESH 8             consecutive mismatches while locked that drop lock
//  CNT_W      16             width of error counter
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  bit_valid  in   1      bit_in is valid this cycle (gaps allowed, any length)
//  bit_in     in   1      received stream bit (generator's shifted-in feedback bit)
//  clr_err    in   1      synchronous clear of err_count (does not affect lock)
//  locked     out  1      checker synchronised and tracking
//  err_pulse  out  1      one-cycle pulse: mismatch on last valid bit while locked
//  err_count  out  CNT_W  saturating count of locked-state mismatches
//  state_o    out  2      current FSM state (debug)
// BEHAVIOUR
//  Reset: sr=0, fill=0, match_cnt=0, miss_cnt=0, state=FILL.
//   Outputs: locked=0, err_pulse=0, err_count=0.
//  Registered: all outputs update on the clk edge that samples bit_valid=1.
//   Latency is 1 cycle. With bit_valid=0, all state holds and err_pulse=0.
//  Per valid bit: exp = ^(sr & TAPS); hit = (bit_in == exp).
//  FSM (state_o encoding 0=FILL, 1=SYNC, 2=LOCK):
//   FILL: sr <= {sr[30:0],bit_in}; fill++.
//    When fill reaches 32 (32nd valid bit), go to SYNC with match_cnt=0.
//   SYNC: sr <= {sr[30:0],bit_in} (self-sync: always load received bit).
//    On hit with sr!=0: match_cnt++. On a miss, or when sr==0: match_cnt=0.
//    The sr==0 rule blocks lock on the degenerate all-zero stream.
//    When match_cnt reaches LOCK_CNT: go to LOCK; locked=1 on that same edge.
//   LOCK: flywheel. sr <= {sr[30:0],exp}; the expected bit is inserted,
//    not bit_in, so isolated errors do not corrupt the predictor.
//    Hit: miss_cnt=0.
//    Miss: err_pulse=1, err_count++ (saturates at all-ones), miss_cnt++.
//    When miss_cnt reaches LOSS_THRESH: locked=0, go to FILL; fill, match_cnt
//     and miss_cnt cleared; sr retained but overwritten by the refill.
//    Bits that miss in SYNC or FILL never pulse or count.
//  clr_err: err_count <= 0. If it coincides with a counted miss, result is 1
//   (the clear applies first, then the increment).
//  rst has priority over everything, including mid-FILL and mid-LOCK.
//  Equivalence: after 32 consecutive valid bits, sr equals the generator's
//   data register. exp then equals the generator's next feedback bit.
// TESTING
//  1 Generator seed 32'h1, bit_valid=1 every cycle
//    -> state FILL->SYNC at bit 32; locked=1 exactly at bit 32+64=96;
//       err_pulse never asserts.
//  2 After lock, invert one bit
//    -> err_pulse=1 for one cycle; err_count=1; locked stays 1;
//       the next 1000 bits produce no further errors.
//  3 After lock, invert 8 consecutive bits
//    -> err_count=8; locked=0 on the 8th; relock after a further 96 clean bits.
//  4 bit_valid toggled 1/0 randomly with the generator stepping only on valid
//    -> lock at valid bit 96 and zero errors, independent of gap pattern.
//  5 Constant bit_in=0 for 500 valid bits
//    -> never locks; err_count stays 0.
//  6 rst pulse mid-LOCK, and clr_err coincident with a miss
//    -> all outputs 0 on the next cycle; err_count=1 after the coincident clear.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// Stream and status bundle for the LFSR checker: the bit source drives the
// master side and the checker is the slave.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_valid;
  logic             bit_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       state_o;

  modport master (
    output bit_valid, bit_in, clr_err,
    input  locked, err_pulse, err_count, state_o
  );

  modport slave (
    input  bit_valid, bit_in, clr_err,
    output locked, err_pulse, err_count, state_o
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side checker for a 32-bit Fibonacci LFSR stream. It fills and
// self-synchronises on the received bits, then flywheels on its own prediction.
module lfsr_checker #(
  parameter logic [31:0] TAPS        = 32'h9010_2302,
  parameter int          LOCK_CNT    = 64,
  parameter int          LOSS_THRESH = 8,
  parameter int          CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  lfsr_checker_if.slave bus
);

  localparam int FILL_W  = 5;
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [31:0]        sr_q,        sr_d;
  logic [FILL_W-1:0]  fill_q,      fill_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]  miss_cnt_q,  miss_cnt_d;
  logic               locked_q,    locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic exp_bit;
  logic hit;

  assign exp_bit = ^(sr_q & TAPS);
  assign hit     = (bus.bit_in == exp_bit);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = bus.clr_err ? '0 : err_count_q;

    if (bus.bit_valid) begin
      unique case (state_q)
        ST_FILL: begin
          sr_d = {sr_q[30:0], bus.bit_in};
          if (fill_q == FILL_W'(31)) begin
            state_d     = ST_SYNC;
            fill_d      = '0;
            match_cnt_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        ST_SYNC: begin
          sr_d = {sr_q[30:0], bus.bit_in};
          // An all-zero register predicts zeros forever, so it never counts toward lock.
          if (hit && (sr_q != '0)) begin
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d     = ST_LOCK;
              locked_d    = 1'b1;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end

        ST_LOCK: begin
          sr_d = {sr_q[30:0], exp_bit};
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_d != '1) err_count_d = err_count_d + 1'b1;
            if (miss_cnt_q == MISS_W'(LOSS_THRESH - 1)) begin
              state_d     = ST_FILL;
              locked_d    = 1'b0;
              fill_d      = '0;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end
        end

        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_FILL;
      sr_q        <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus pushes the expected outputs for
// every sampled bit, and a negedge monitor pops and compares them.
module tb_lfsr_checker;

  localparam logic [31:0] TAPS    = 32'h9010_2302;
  localparam logic [1:0]  S_FILL  = 2'd0;
  localparam logic [1:0]  S_SYNC  = 2'd1;
  localparam logic [1:0]  S_LOCK  = 2'd2;

  typedef struct packed {
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) bus ();

  lfsr_checker #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] gen;
  logic        sampled_evt = 1'b0;
  logic        armed       = 1'b0;
  string       phase       = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic l, input logic p, input logic [15:0] c, input logic [1:0] s);
    exp_t e;
    e.locked    = l;
    e.err_pulse = p;
    e.err_count = c;
    e.state     = s;
    return e;
  endfunction

  // Expected outputs after the k-th clean bit since the last reset or loss of lock.
  function automatic exp_t acq_exp(input int k, input logic [15:0] c);
    logic [1:0] s;
    s = (k < 32) ? S_FILL : (k < 96) ? S_SYNC : S_LOCK;
    return mk(k >= 96, 1'b0, c, s);
  endfunction

  function automatic logic gen_step();
    logic fb;
    fb  = ^(gen & TAPS);
    gen = {gen[30:0], fb};
    return fb;
  endfunction

  task automatic drive(input logic v, input logic b, input logic c, input logic r);
    @(negedge clk);
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.clr_err   = c;
    rst           = r;
  endtask

  task automatic send(input logic b, input exp_t e, input logic c = 1'b0);
    drive(1'b1, b, c, 1'b0);
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic c);
    drive(1'b0, 1'b0, c, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    sb_q.push_back(mk(1'b0, 1'b0, 16'd0, S_FILL));
  endtask

  task automatic acquire(input int n, input logic [15:0] c, input bit gaps);
    for (int k = 1; k <= n; k++) begin
      send(gen_step(), acq_exp(k, c));
      if (gaps) begin
        int g;
        g = $urandom_range(3, 0);
        for (int j = 0; j < g; j++) idle(1'b0);
      end
    end
  endtask

  always @(posedge clk) sampled_evt <= bus.bit_valid | rst;

  always @(negedge clk) begin
    if (sampled_evt) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s/scoreboard: output sampled with no expectation queued at %0t", phase, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("locked",    32'(bus.locked),    32'(mon_e.locked));
        check("err_pulse", 32'(bus.err_pulse), 32'(mon_e.err_pulse));
        check("err_count", 32'(bus.err_count), 32'(mon_e.err_count));
        check("state_o",   32'(bus.state_o),   32'(mon_e.state));
      end
    end else if (armed) begin
      check("idle_err_pulse", 32'(bus.err_pulse), 32'd0);
    end
  end

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clr_err   = 1'b0;

    phase = "reset";
    do_reset();
    do_reset();
    idle(1'b0);
    idle(1'b0);
    armed = 1'b1;

    // Seed 1, continuous stream: SYNC after bit 32, lock exactly at bit 96.
    phase = "t1_lock";
    gen = 32'h1;
    acquire(100, 16'd0, 1'b0);

    // One corrupted bit while locked: single pulse, count 1, lock held.
    phase = "t2_single_err";
    send(~gen_step(), mk(1'b1, 1'b1, 16'd1, S_LOCK));
    for (int i = 0; i < 1000; i++) send(gen_step(), mk(1'b1, 1'b0, 16'd1, S_LOCK));

    // Clear on an idle cycle, then 8 corrupted bits drop lock; relock after 96 clean bits.
    phase = "t3_burst";
    idle(1'b1);
    for (int i = 1; i <= 8; i++)
      send(~gen_step(), mk(i < 8, 1'b1, 16'(i), (i < 8) ? S_LOCK : S_FILL));
    acquire(100, 16'd8, 1'b0);

    // Random gaps between valid bits do not change where lock lands.
    phase = "t4_gaps";
    do_reset();
    gen = 32'hACE1_2345;
    acquire(100, 16'd0, 1'b1);

    // All-zero stream never locks and never counts.
    phase = "t5_zeros";
    do_reset();
    for (int k = 1; k <= 500; k++)
      send(1'b0, mk(1'b0, 1'b0, 16'd0, (k < 32) ? S_FILL : S_SYNC));

    // clr_err coinciding with a counted miss leaves 1; rst mid-LOCK zeroes everything.
    phase = "t6_clr_rst";
    do_reset();
    gen = 32'h1357_9BDF;
    acquire(96, 16'd0, 1'b0);
    send(~gen_step(), mk(1'b1, 1'b1, 16'd1, S_LOCK));
    for (int i = 0; i < 5; i++) send(gen_step(), mk(1'b1, 1'b0, 16'd1, S_LOCK));
    send(~gen_step(), mk(1'b1, 1'b1, 16'd1, S_LOCK), 1'b1);
    for (int i = 0; i < 3; i++) send(gen_step(), mk(1'b1, 1'b0, 16'd1, S_LOCK));
    do_reset();
    gen = 32'hDEAD_BEEF;
    acquire(3, 16'd0, 1'b0);

    phase = "drain";
    idle(1'b0);
    idle(1'b0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
